// File: rtl/wb_echo.sv
// wb_echo: Wishbone echo-pulse width timer with timeout and level IRQ; `WB_ECHO_GLITCH_FILTER_EN adds a 4-sample stability filter
module wb_echo #(
    parameter int          cnt_width       = 24,
    parameter logic [31:0] timeout_default = 32'd3000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        echo_i,
    output logic        intr
);
    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_RISE, MEASURE} state_t;
    localparam logic [cnt_width-1:0] cnt_max = '1;
    localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};
    state_t state, state_nx;
    logic [cnt_width-1:0] width_cnt, tmo_cnt, width, timeout;
    logic irq_en, arm, done, tmo, ovf;
    logic s1, s2, lvl, prev, rise, fall, tmo_hit;
    logic acc, wr, busy;
    logic [1:0] adr;
    logic [2:0] w1c;
    logic [31:0] rdata;
    logic start, inc, run, set_done, set_tmo;
    logic unused;
    assign unused = ^{wb_adr_i, wb_dat_i, wb_sel_i};
    assign adr = wb_adr_i[3:2];
    assign acc = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr = acc & wb_we_i & wb_sel_i[0];
    assign w1c = (wr && adr == 2'd1) ? wb_dat_i[3:1] : 3'b0;
    assign busy = state != IDLE;
    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;
    assign tmo_hit = timeout != '0 && tmo_cnt == timeout;
    assign rdata = adr == 2'd0 ? {30'b0, irq_en, 1'b0} :
                   adr == 2'd1 ? {28'b0, ovf, tmo, done, busy} :
                   adr == 2'd2 ? 32'(width) : 32'(timeout);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= echo_i;
            s2   <= s1;
            prev <= lvl;
        end
    end
`ifdef WB_ECHO_GLITCH_FILTER_EN
    logic filt;
    logic [1:0] stab;
    // level flips only after four consecutive samples disagree with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
            stab <= 2'd0;
        end else if (s2 == filt) begin
            stab <= 2'd0;
        end else if (stab == 2'd3) begin
            filt <= s2;
            stab <= 2'd0;
        end else begin
            stab <= stab + 2'd1;
        end
    end
    assign lvl = filt;
`else
    assign lvl = s2;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // a falling edge beats a simultaneous timeout; ARM restarts from any state
    always_comb begin
        state_nx = arm ? WAIT_LOW :
                   (state == MEASURE && fall) ? IDLE :
                   (state != IDLE && tmo_hit) ? IDLE :
                   (state == WAIT_LOW && !lvl) ? WAIT_RISE :
                   (state == WAIT_RISE && rise) ? MEASURE : state;
    end
    always_comb begin
        run      = !arm && busy;
        set_done = run && state == MEASURE && fall;
        set_tmo  = run && tmo_hit && !set_done;
        start    = run && state == WAIT_RISE && rise && !tmo_hit;
        inc      = run && state == MEASURE && lvl && !tmo_hit;
    end
    // status sets take priority over a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width_cnt <= '0;
            tmo_cnt   <= '0;
            width     <= '0;
            done      <= 1'b0;
            tmo       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            tmo_cnt   <= arm ? '0 : run ? tmo_cnt + cnt_one : tmo_cnt;
            width_cnt <= arm ? '0 : start ? cnt_one :
                         (inc && width_cnt != cnt_max) ? width_cnt + cnt_one : width_cnt;
            ovf       <= arm ? 1'b0 : (inc && width_cnt == cnt_max) ? 1'b1 : ovf & ~w1c[2];
            width     <= set_done ? width_cnt : width;
            done      <= set_done | (done & ~w1c[0]);
            tmo       <= set_tmo | (tmo & ~w1c[1]);
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            intr     <= 1'b0;
            arm      <= 1'b0;
            irq_en   <= 1'b0;
            timeout  <= timeout_default[cnt_width-1:0];
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= acc ? rdata : '0;
            arm      <= wr && adr == 2'd0 && wb_dat_i[0];
            irq_en   <= (wr && adr == 2'd0) ? wb_dat_i[1] : irq_en;
            timeout  <= (wr && adr == 2'd3) ? wb_dat_i[cnt_width-1:0] : timeout;
            intr     <= irq_en & (done | tmo);
        end
    end
endmodule

// File: doc/wb_echo.md
# wb_echo

Wishbone slave that measures the high time of the ultrasonic sensor's echo pulse, the receive half of the trigger output path. The CPU arms a measurement after firing the trigger. The block times the next echo pulse in clock cycles, flags a timeout if no echo completes, and raises a level interrupt. It sits on conbus slot s6 at 0x70000000 next to the trigger peripheral.

## Interface
- `cnt_width`, 24, width of the width and timeout counters (8..32).
- `timeout_default`, 3000000, reset value of the TIMEOUT register in cycles (30 ms at 100 MHz).
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  reset; asynchronous, active-low.
- `wb_adr_i`  in  32  byte address; only [3:2] decoded.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, registered.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i`  in  1  Wishbone strobe, cycle and write enable.
- `wb_sel_i`  in  4  byte selects; writes require `wb_sel_i[0]`, otherwise the write is ignored but still acked.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `echo_i`  in  1  asynchronous echo pin.
- `intr`  out  1  active-high level interrupt.

## Operation
- Register map:
  - 0x0 CTRL: bit0 ARM (write 1, self-clearing, reads 0); bit1 IRQ_EN (R/W).
  - 0x4 STATUS: bit0 BUSY (RO); bit1 DONE; bit2 TIMEOUT; bit3 OVF. Bits 1..3 are write-1-to-clear.
  - 0x8 WIDTH: RO, last measured high time in cycles, zero-extended.
  - 0xC TIMEOUT: R/W, low `cnt_width` bits are the timeout limit in cycles.
- `echo_i` passes through a 2-FF synchronizer, then a registered previous-value stage for edge detection.
- FSM states:
  - IDLE: ARM clears WIDTH_CNT, TMO_CNT and OVF, then goes to WAIT_LOW.
  - WAIT_LOW: go to WAIT_RISE when synchronized echo = 0. This guarantees a fresh pulse is measured.
  - WAIT_RISE: on a rising edge, go to MEASURE with WIDTH_CNT = 1.
  - MEASURE: increment WIDTH_CNT while echo is high. On the falling edge, WIDTH <= WIDTH_CNT, DONE <= 1, go to IDLE.
- TMO_CNT runs in WAIT_LOW, WAIT_RISE and MEASURE.
  - When TMO_CNT == TIMEOUT: set TIMEOUT, go to IDLE, leave WIDTH unchanged.
  - TIMEOUT = 0 means the timeout never fires.
- WIDTH_CNT saturates at 2^cnt_width-1 and sets OVF; the measurement still ends on the falling edge.
- BUSY = (state != IDLE).
- `intr` = IRQ_EN & (DONE | TIMEOUT), registered.
- Boundary behaviour:
  - ARM while BUSY restarts cleanly from WAIT_LOW.
  - A W1C of DONE in the same cycle the FSM sets DONE: set wins.
  - Falling edge and timeout in the same cycle: the falling edge wins (DONE, WIDTH updated).
  - Reset asserted mid-measurement aborts the measurement and returns to IDLE.
- Reset values:
  - `wb_ack_o`, `wb_dat_o`, `intr` = 0.
  - State IDLE; CTRL, STATUS, WIDTH = 0.
  - TIMEOUT = `timeout_default`; synchronizer FFs = 0.

## Timing
- Wishbone: `wb_ack_o` rises one cycle after `wb_stb_i & wb_cyc_i & ~wb_ack_o`, then drops for at least one cycle (no back-to-back acks).
- `wb_dat_o` is valid in the same cycle as `wb_ack_o`.
- Writes take effect on the ack edge; ARM is seen by the FSM the following cycle.
- Echo edge latency is 3 cycles from `echo_i` to FSM action, equal on both edges. A pulse held high N cycles, synchronous to `clk`, yields WIDTH = N exactly.
- DONE and WIDTH update on the same edge; `intr` follows one cycle later.
- Pulses shorter than 2 cycles may be missed; this is not required to be detected.

## Configuration
- `WB_ECHO_GLITCH_FILTER_EN` defined:
  - A 4-cycle majority-free stability filter follows the synchronizer; the filtered level changes only after 4 consecutive identical samples.
  - Edge latency becomes 7 cycles on both edges, so WIDTH is still exact.
  - Pulses or gaps shorter than 4 cycles are ignored.
- Undefined: no filter; latency as in Timing.

## Test plan
- Write CTRL=0x3; drive `echo_i` high for 5800 cycles -> BUSY=1 during the measurement; WIDTH=5800, DONE=1, `intr`=1 within 5 cycles of the falling edge.
- TIMEOUT=1000, arm, keep echo low -> TIMEOUT bit set 1000 cycles after arm, WIDTH unchanged, BUSY=0.
- Echo already high at arm, falls, then a 200-cycle pulse -> WIDTH=200, not the partial first pulse.
- `cnt_width`=8, TIMEOUT=0, 300-cycle pulse -> WIDTH=255, OVF=1, DONE=1.
- Re-arm mid-pulse at cycle 100 of a 500-cycle pulse, then a 50-cycle pulse -> WIDTH=50; write STATUS=0x6 -> DONE/TIMEOUT cleared, `intr`=0.
- Assert reset during MEASURE -> all outputs 0, TIMEOUT reads `timeout_default`; with the filter macro, 3-cycle glitches never set DONE.
